// File: rtl/hvac_sequencer.sv
// rtl/hvac_sequencer.sv - sampled-temperature HVAC mode sequencer with debounce, hold and dead time
module hvac_sequencer #(
  parameter logic [7:0] TEMP_LOW    = 8'd20,
  parameter logic [7:0] TEMP_MED    = 8'd30,
  parameter logic [7:0] TEMP_HIGH   = 8'd45,
  parameter int         MIN_HOLD    = 4,
  parameter int         DEAD_CYCLES = 3,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  output logic       sense_req,
  input  logic       sense_ack,
  input  logic [7:0] sense_data,
  output logic       heater_on,
  output logic       cooler_on,
  output logic       AC_on,
  output logic [1:0] mode,
  output logic       busy,
  output logic       sensor_fault,
  output logic       tick_missed
);

  localparam logic [3:0] HOLD_SAT  = 4'(MIN_HOLD);
  localparam logic [3:0] DEAD_LAST = 4'(DEAD_CYCLES - 1);
  localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);

  localparam logic [1:0] M_OFF  = 2'd0;
  localparam logic [1:0] M_HEAT = 2'd1;
  localparam logic [1:0] M_COOL = 2'd2;
  localparam logic [1:0] M_AC   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EVAL, S_DEAD} state_t;

  state_t     state;
  logic [7:0] sense_q;
  logic [7:0] req_cnt;
  logic [3:0] hold;
  logic [3:0] dead_cnt;
  logic       pend_valid;
  logic [1:0] pend_zone;
  logic [1:0] target;
  logic [1:0] zone;
  logic       change_ok;

  // Classify the captured sample into the mode its temperature zone calls for
  always_comb begin
    zone = M_OFF;
    if (sense_q < TEMP_LOW)
      zone = M_HEAT;
    else if (sense_q < TEMP_MED)
      zone = M_OFF;
    else if (sense_q < TEMP_HIGH)
      zone = M_COOL;
    else
      zone = M_AC;
  end

  // A change needs the same new zone twice in a row and a fully served hold period
  assign change_ok = pend_valid && (pend_zone == zone) && (hold >= HOLD_SAT);

  // Sequencer: sample handshake, debounced decision, break-before-make dead time
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      sense_req    <= 1'b0;
      heater_on    <= 1'b0;
      cooler_on    <= 1'b0;
      AC_on        <= 1'b0;
      mode         <= M_OFF;
      busy         <= 1'b0;
      sensor_fault <= 1'b0;
      tick_missed  <= 1'b0;
      sense_q      <= 8'd0;
      req_cnt      <= 8'd0;
      hold         <= HOLD_SAT;
      dead_cnt     <= 4'd0;
      pend_valid   <= 1'b0;
      pend_zone    <= M_OFF;
      target       <= M_OFF;
    end else begin
      // A tick is only served from IDLE; anywhere else it is reported and dropped
      tick_missed <= sample_tick && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            state     <= S_REQ;
            sense_req <= 1'b1;
            busy      <= 1'b1;
            req_cnt   <= 8'd0;
          end
        end
        S_REQ: begin
          if (sense_ack) begin
            sense_q   <= sense_data;
            sense_req <= 1'b0;
            state     <= S_EVAL;
          end else if (req_cnt == ACK_LAST) begin
            // Sensor is silent: fail safe to OFF at once, no dead time needed
            sense_req    <= 1'b0;
            state        <= S_IDLE;
            busy         <= 1'b0;
            sensor_fault <= 1'b1;
            heater_on    <= 1'b0;
            cooler_on    <= 1'b0;
            AC_on        <= 1'b0;
            mode         <= M_OFF;
            pend_valid   <= 1'b0;
            hold         <= HOLD_SAT;
          end else begin
            req_cnt <= req_cnt + 8'd1;
          end
        end
        S_EVAL: begin
          sensor_fault <= 1'b0;
          if (hold < HOLD_SAT)
            hold <= hold + 4'd1;
          if (zone == mode) begin
            pend_valid <= 1'b0;
            state      <= S_IDLE;
            busy       <= 1'b0;
          end else if (change_ok) begin
            heater_on <= 1'b0;
            cooler_on <= 1'b0;
            AC_on     <= 1'b0;
            target    <= zone;
            dead_cnt  <= 4'd0;
            state     <= S_DEAD;
          end else begin
            pend_valid <= 1'b1;
            pend_zone  <= zone;
            state      <= S_IDLE;
            busy       <= 1'b0;
          end
        end
        S_DEAD: begin
          if (dead_cnt == DEAD_LAST) begin
            mode       <= target;
            heater_on  <= (target == M_HEAT);
            cooler_on  <= (target == M_COOL);
            AC_on      <= (target == M_AC);
            hold       <= 4'd0;
            pend_valid <= 1'b0;
            state      <= S_IDLE;
            busy       <= 1'b0;
          end else begin
            dead_cnt <= dead_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hvac_sequencer.sv
// tb/tb_hvac_sequencer.sv - directed bench with a procedural reference model of the sequencer
module tb_hvac_sequencer;

  localparam int MIN_HOLD    = 4;
  localparam int DEAD_CYCLES = 3;
  localparam int ACK_TIMEOUT = 16;
  localparam int T_LOW       = 20;
  localparam int T_MED       = 30;
  localparam int T_HIGH      = 45;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick = 1'b0;
  logic       sense_ack = 1'b0;
  logic [7:0] sense_data = 8'd0;
  logic       sense_req;
  logic       heater_on;
  logic       cooler_on;
  logic       AC_on;
  logic [1:0] mode;
  logic       busy;
  logic       sensor_fault;
  logic       tick_missed;

  int checks = 0;
  int errors = 0;

  hvac_sequencer #(
    .TEMP_LOW(8'd20), .TEMP_MED(8'd30), .TEMP_HIGH(8'd45),
    .MIN_HOLD(MIN_HOLD), .DEAD_CYCLES(DEAD_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .sense_req(sense_req),
    .sense_ack(sense_ack), .sense_data(sense_data), .heater_on(heater_on),
    .cooler_on(cooler_on), .AC_on(AC_on), .mode(mode), .busy(busy),
    .sensor_fault(sensor_fault), .tick_missed(tick_missed)
  );

  always #5 clk = ~clk;

  // model expectations
  bit ab       = 1'b0;
  int e_mode   = 0;
  bit e_req    = 1'b0;
  bit e_busy   = 1'b0;
  bit e_fault  = 1'b0;
  bit e_missed = 1'b0;
  bit e_dead   = 1'b0;
  int hold     = MIN_HOLD;
  bit pend_v   = 1'b0;
  int pend_z   = 0;

  function automatic int zone_of(input int t);
    if (t < T_LOW)  return 1;
    if (t < T_MED)  return 0;
    if (t < T_HIGH) return 2;
    return 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk or posedge reset);
    if (reset) ab = 1'b1;
    else e_missed = sample_tick && e_busy;
  endtask

  // Reference model: walks one sample transaction at a time
  initial begin : model
    int z;
    int d;
    int cnt;
    int h;
    bit got;
    @(posedge reset);
    ab = 1'b1;
    forever begin
      if (ab) begin
        ab = 0; e_mode = 0; e_req = 0; e_busy = 0; e_fault = 0; e_missed = 0; e_dead = 0;
        hold = MIN_HOLD; pend_v = 0;
        wait (!reset);
      end
      step();
      if (ab || !sample_tick) continue;
      e_req = 1; e_busy = 1;
      got = 0; cnt = 0; d = 0;
      while (!got && cnt < ACK_TIMEOUT) begin
        step();
        if (ab) break;
        if (sense_ack) begin
          got = 1; d = int'(sense_data); e_req = 0;
        end else begin
          cnt++;
        end
      end
      if (ab) continue;
      if (!got) begin
        e_req = 0; e_busy = 0; e_fault = 1; e_mode = 0; pend_v = 0; hold = MIN_HOLD;
        continue;
      end
      step();
      if (ab) continue;
      e_fault = 0;
      z = zone_of(d);
      h = hold;
      if (hold < MIN_HOLD) hold++;
      if (z == e_mode) begin
        pend_v = 0; e_busy = 0;
      end else if (pend_v && pend_z == z && h >= MIN_HOLD) begin
        e_dead = 1;
        for (int i = 0; i < DEAD_CYCLES; i++) begin
          step();
          if (ab) break;
        end
        if (ab) continue;
        e_dead = 0; e_mode = z; hold = 0; pend_v = 0; e_busy = 0;
      end else begin
        pend_v = 1; pend_z = z; e_busy = 0;
      end
    end
  end

  // Compare every output against the model, away from the active edge
  initial begin
    @(posedge reset);
    forever begin
      @(negedge clk);
      chk("sense_req", sense_req, e_req);
      chk("busy", busy, e_busy);
      chk("mode", mode, e_mode);
      chk("heater_on", heater_on, !e_dead && e_mode == 1);
      chk("cooler_on", cooler_on, !e_dead && e_mode == 2);
      chk("AC_on", AC_on, !e_dead && e_mode == 3);
      chk("sensor_fault", sensor_fault, e_fault);
      chk("tick_missed", tick_missed, e_missed);
    end
  end

  int req_rises = 0;
  initial begin
    logic req_d;
    req_d = 1'b0;
    forever begin
      @(negedge clk);
      if (sense_req && !req_d) req_rises++;
      req_d = sense_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual running required finished");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int t, input int d);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    repeat (d) cyc();
    sense_ack = 1'b1; sense_data = 8'(t); cyc(); sense_ack = 1'b0;
    repeat (6) cyc();
  endtask

  initial begin
    int r0;
    #1 reset = 1'b1;
    repeat (2) cyc();
    chk("rst_mode", mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", sense_req, 0);
    chk("rst_act", heater_on | cooler_on | AC_on, 0);
    chk("rst_fault", sensor_fault, 0);
    reset = 1'b0;
    cyc();

    // debounced change to HEAT with dead time
    sample(15, 1);
    chk("first15_mode", mode, 0);
    chk("first15_heater", heater_on, 0);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    sense_ack = 1'b1; sense_data = 8'd15; cyc(); sense_ack = 1'b0;
    cyc();
    chk("dead1_heater", heater_on, 0);
    chk("dead1_busy", busy, 1);
    cyc(); cyc();
    chk("dead3_heater", heater_on, 0);
    chk("dead3_mode", mode, 0);
    cyc();
    chk("heat_on", heater_on, 1);
    chk("heat_mode", mode, 1);

    // stray acknowledge outside a request
    sense_ack = 1'b1; sense_data = 8'd50; cyc(); sense_ack = 1'b0; cyc();
    chk("stray_ack_busy", busy, 0);
    chk("stray_ack_mode", mode, 1);

    // minimum hold before HEAT -> AC
    for (int i = 0; i < 4; i++) sample(50, 0);
    chk("hold4_heater", heater_on, 1);
    chk("hold4_ac", AC_on, 0);
    sample(50, 2);
    chk("hold5_ac", AC_on, 1);
    chk("hold5_heater", heater_on, 0);
    chk("hold5_mode", mode, 3);

    // tick during REQ is dropped
    r0 = req_rises;
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0; cyc();
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    chk("busy_tick_pulse", tick_missed, 1);
    cyc();
    chk("busy_tick_clear", tick_missed, 0);
    sense_ack = 1'b1; sense_data = 8'd50; cyc(); sense_ack = 1'b0;
    repeat (6) cyc();
    chk("busy_tick_rises", req_rises - r0, 1);

    // AC -> COOL
    repeat (3) sample(35, 1);
    chk("to_cool_pending", AC_on, 1);
    sample(35, 1);
    chk("cool_on", cooler_on, 1);
    chk("cool_mode", mode, 2);

    // acknowledge timeout
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    repeat (15) cyc();
    chk("to_req_held", sense_req, 1);
    chk("to_cool_held", cooler_on, 1);
    cyc();
    chk("to_req_drop", sense_req, 0);
    chk("to_fault", sensor_fault, 1);
    chk("to_cooler", cooler_on, 0);
    chk("to_mode", mode, 0);
    chk("to_busy", busy, 0);
    sample(25, 0);
    chk("fault_clear", sensor_fault, 0);

    // debounce reject
    sample(35, 1);
    chk("rej1_mode", mode, 0);
    sample(25, 1);
    chk("rej2_mode", mode, 0);
    sample(35, 1);
    chk("rej3_mode", mode, 0);
    chk("rej3_cooler", cooler_on, 0);
    sample(35, 1);
    chk("rej_then_cool", mode, 2);

    // reset in the middle of DEAD
    for (int i = 0; i < 4; i++) sample(15, 1);
    chk("pre_dead_mode", mode, 2);
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
    sense_ack = 1'b1; sense_data = 8'd15; cyc(); sense_ack = 1'b0;
    cyc(); cyc();
    chk("dead2_busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("mdr_mode", mode, 0);
    chk("mdr_busy", busy, 0);
    chk("mdr_act", heater_on | cooler_on | AC_on, 0);
    chk("mdr_req", sense_req, 0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    sample(15, 1);
    chk("post_rst_first", heater_on, 0);
    sample(15, 1);
    chk("post_rst_heat", heater_on, 1);
    chk("post_rst_mode", mode, 1);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
